control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  K&S processor control FSM; direct neighbour of the data path. Consumes the decoded instruction and the
//  registered flags from the data path. Drives every data-path enable/select plus RAM write enable.
//  Sequences fetch/decode/execute per instruction, halts on I_HALT, counts retired instructions.
// PARAMETERS
//  CNT_W  16  width of retired-instruction counter (saturating)
// PORTS
//  clk                 in   1      clock, all state on rising edge
//  rst_n               in   1      reset, asynchronous, active-low
//  start               in   1      leave IDLE and begin fetching at current PC
//  decoded_instruction in   enum   decoded_instruction_type from data path (from registered IR)
//  zero_op             in   1      registered zero flag
//  neg_op              in   1      registered negative flag
//  unsigned_overflow   in   1      registered unsigned overflow flag
//  signed_overflow     in   1      registered signed overflow flag
//  branch              out  1      PC loads mem_addr (else PC+1) when pc_enable
//  pc_enable           out  1      PC update strobe
//  ir_enable           out  1      IR captures data_in
//  addr_sel            out  1      1: ram_addr=mem_addr, 0: ram_addr=PC
//  c_sel               out  1      1: bus_c=ALU result, 0: bus_c=data_in
//  operation           out  2      ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//  write_reg_enable    out  1      register file write strobe
//  flags_reg_enable    out  1      flags register capture strobe
//  ram_write_enable    out  1      RAM write strobe (data = data_out)
//  halt                out  1      processor halted
//  instr_count         out  CNT_W  retired instructions since reset, saturates at all-ones
// BEHAVIOUR
//  - RAM: asynchronous read, synchronous write. All outputs combinational from state (+ decoded_instruction/flags in DECODE/EXEC).
//  - Reset (async, any state, mid-instruction included): state=IDLE, instr_count=0; every output 0 immediately.
//  - Default of every strobe/select in every state is 0; operation defaults 2'b00.
//  - IDLE: all 0; start=1 -> FETCH next edge; start=0 -> stay.
//  - FETCH: addr_sel=0, ir_enable=1 -> DECODE.
//  - DECODE (IR now valid):
//    I_BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV: pc_enable=1, branch=taken -> FETCH, retire.
//      taken: BRANCH 1; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV signed_overflow; BNOV !signed_overflow.
//    I_NOP and any unlisted encoding: pc_enable=1, branch=0 -> FETCH, retire.
//    I_LOAD/STORE/MOVE/ADD/SUB/AND/OR: pc_enable=1, branch=0 -> EXEC.
//    I_HALT: no PC update -> HALT, retire.
//  - EXEC (by decoded_instruction, IR unchanged) -> FETCH, retire:
//    LOAD : addr_sel=1, c_sel=0, write_reg_enable=1.
//    STORE: addr_sel=1, ram_write_enable=1.
//    MOVE : c_sel=1, operation=00 (a|a), write_reg_enable=1; flags NOT updated.
//    ADD/SUB/AND/OR: c_sel=1, operation=01/10/11/00, write_reg_enable=1, flags_reg_enable=1.
//  - HALT: halt=1, all strobes 0, start ignored; exit only via rst_n.
//  - Latency: branch/NOP/HALT 2 cycles (FETCH,DECODE); others 3 cycles (FETCH,DECODE,EXEC).
//  - Branch uses flags registered by the most recent flag-updating ALU op; never same-cycle values.
//  - "retire": instr_count+1 on that edge unless already all-ones (saturate, no wrap).
// STRUCTURE
//  - k_and_s_pkg: add ctrl_state_t {IDLE,FETCH,DECODE,EXEC,HALT}; ALU op constants OP_OR=2'b00,
//    OP_ADD=2'b01, OP_SUB=2'b10, OP_AND=2'b11 (data path switches to them too).
//  - One sub-module: branch_eval (comb: decoded_instruction + 4 flags -> is_branch, taken).
//  - Single state register + next-state/output always_comb; separate counter always_ff.
// TESTING
//  1 rst_n low 3 cycles, start=0 for 10 cycles -> all outputs 0, halt=0, instr_count=0.
//  2 start=1, decoded=I_ADD -> c1 addr_sel=0 ir_enable=1; c2 pc_enable=1 branch=0; c3 operation=01
//    c_sel=1 write_reg_enable=1 flags_reg_enable=1; then FETCH, instr_count=1.
//  3 I_BZERO zero_op=1 -> DECODE pc_enable=1 branch=1; repeat zero_op=0 -> branch=0; I_BNOV signed_overflow=1 -> branch=0.
//  4 I_STORE -> EXEC addr_sel=1 ram_write_enable=1 write_reg_enable=0; I_MOVE -> write_reg_enable=1 flags_reg_enable=0 operation=00.
//  5 I_HALT -> after DECODE halt=1, all strobes 0 for 20 cycles with start=1, count unchanged; rst_n pulse -> IDLE, halt=0.
//  6 rst_n low mid-EXEC of I_LOAD -> write_reg_enable drops before next edge, count=0;
//    CNT_W=2, run 5 I_NOP -> instr_count stays 3.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// K&S processor shared types: decoded instructions, control FSM states, ALU ops.
// Imported by the control unit, its interface and the data path.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
  } ctrl_out_t;

endpackage

// File: rtl/control_unit_if.sv
// Control <-> data path bundle: decoded IR + registered flags in, strobes out.
// master = control unit, slave = data path.
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;

  modport master (
    input  decoded_instruction,
    input  zero_op,
    input  neg_op,
    input  unsigned_overflow,
    input  signed_overflow,
    output branch,
    output pc_enable,
    output ir_enable,
    output addr_sel,
    output c_sel,
    output operation,
    output write_reg_enable,
    output flags_reg_enable,
    output ram_write_enable
  );

  modport slave (
    output decoded_instruction,
    output zero_op,
    output neg_op,
    output unsigned_overflow,
    output signed_overflow,
    input  branch,
    input  pc_enable,
    input  ir_enable,
    input  addr_sel,
    input  c_sel,
    input  operation,
    input  write_reg_enable,
    input  flags_reg_enable,
    input  ram_write_enable
  );

endinterface

// File: rtl/control_unit_branch_eval.sv
// Branch classifier: decoded instruction + registered flags -> is_branch, taken.
// Ports: instr, zero_op, neg_op, signed_overflow in; is_branch, taken out.
module control_unit_branch_eval
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type instr,
  input  logic zero_op,
  input  logic neg_op,
  input  logic signed_overflow,
  output logic is_branch,
  output logic taken
);

  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = signed_overflow;
      I_BNOV:   taken = !signed_overflow;
      default:  is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// K&S control FSM: sequences fetch/decode/execute, halts, counts retirements.
// Ports: clk, rst_n, start, cif (master), halt, instr_count.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  control_unit_if.master   cif,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_out_t        o;
  logic             retire;
  logic             is_branch;
  logic             taken;

  control_unit_branch_eval u_branch_eval (
    .instr           (cif.decoded_instruction),
    .zero_op         (cif.zero_op),
    .neg_op          (cif.neg_op),
    .signed_overflow (cif.signed_overflow),
    .is_branch       (is_branch),
    .taken           (taken)
  );

  always_comb begin
    state_d = state_q;
    o       = '0;
    halt    = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        o.ir_enable = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        if (is_branch) begin
          o.pc_enable = 1'b1;
          o.branch    = taken;
          state_d     = FETCH;
          retire      = 1'b1;
        end else begin
          case (cif.decoded_instruction)
            I_LOAD, I_STORE, I_MOVE,
            I_ADD, I_SUB, I_AND, I_OR: begin
              o.pc_enable = 1'b1;
              state_d     = EXEC;
            end
            I_HALT: begin
              state_d = HALT;
              retire  = 1'b1;
            end
            default: begin
              o.pc_enable = 1'b1;
              state_d     = FETCH;
              retire      = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        state_d = FETCH;
        retire  = 1'b1;
        case (cif.decoded_instruction)
          I_LOAD: begin
            o.addr_sel         = 1'b1;
            o.write_reg_enable = 1'b1;
          end
          I_STORE: begin
            o.addr_sel         = 1'b1;
            o.ram_write_enable = 1'b1;
          end
          I_MOVE: begin
            o.c_sel            = 1'b1;
            o.operation        = OP_OR;
            o.write_reg_enable = 1'b1;
          end
          I_ADD, I_SUB, I_AND, I_OR: begin
            o.c_sel            = 1'b1;
            o.write_reg_enable = 1'b1;
            o.flags_reg_enable = 1'b1;
            case (cif.decoded_instruction)
              I_ADD:   o.operation = OP_ADD;
              I_SUB:   o.operation = OP_SUB;
              I_AND:   o.operation = OP_AND;
              default: o.operation = OP_OR;
            endcase
          end
          default: ;
        endcase
      end
      HALT: begin
        halt = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturate at all-ones rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cif.branch           = o.branch;
  assign cif.pc_enable        = o.pc_enable;
  assign cif.ir_enable        = o.ir_enable;
  assign cif.addr_sel         = o.addr_sel;
  assign cif.c_sel            = o.c_sel;
  assign cif.operation        = o.operation;
  assign cif.write_reg_enable = o.write_reg_enable;
  assign cif.flags_reg_enable = o.flags_reg_enable;
  assign cif.ram_write_enable = o.ram_write_enable;
  assign instr_count          = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes expected outputs,
// a negedge monitor pops and compares. Second instance uses CNT_W=2.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n2 = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic halt, halt2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  control_unit_if cif ();
  control_unit_if cif2 ();

  control_unit #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cif         (cif.master),
    .halt        (halt),
    .instr_count (cnt1)
  );

  control_unit #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n2),
    .start       (start2),
    .cif         (cif2.master),
    .halt        (halt2),
    .instr_count (cnt2)
  );

  always #5 clk = ~clk;

  logic [10:0] vec1, vec2;
  assign vec1 = {cif.branch, cif.pc_enable, cif.ir_enable,
                 cif.addr_sel, cif.c_sel, cif.operation,
                 cif.write_reg_enable, cif.flags_reg_enable,
                 cif.ram_write_enable, halt};
  assign vec2 = {cif2.branch, cif2.pc_enable, cif2.ir_enable,
                 cif2.addr_sel, cif2.c_sel, cif2.operation,
                 cif2.write_reg_enable, cif2.flags_reg_enable,
                 cif2.ram_write_enable, halt2};

  typedef struct {
    string       nm;
    bit          d2;
    logic [10:0] v;
    logic [15:0] c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  function automatic logic [10:0] mk(
    input bit br, input bit pc, input bit ir, input bit as,
    input bit cs, input logic [1:0] op, input bit wre,
    input bit fre, input bit rwe, input bit h);
    return {br, pc, ir, as, cs, op, wre, fre, rwe, h};
  endfunction

  logic [10:0] VZ, VF, VDN, VDB, VH;
  logic [10:0] VADD, VSUB, VST, VMV, VLD;

  task automatic cyc(input string nm, input bit d2, input logic r,
                     input logic st, input decoded_instruction_type ins,
                     input logic z, input logic n, input logic ov,
                     input logic [10:0] v, input int c);
    exp_t e;
    @(posedge clk);
    #1;
    if (d2) begin
      rst_n2 = r;
      start2 = st;
      cif2.decoded_instruction = ins;
      cif2.zero_op = z;
      cif2.neg_op = n;
      cif2.signed_overflow = ov;
    end else begin
      rst_n = r;
      start = st;
      cif.decoded_instruction = ins;
      cif.zero_op = z;
      cif.neg_op = n;
      cif.signed_overflow = ov;
    end
    e.nm = nm;
    e.d2 = d2;
    e.v  = v;
    e.c  = 16'(c);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] av;
      logic [15:0] ac;
      e  = q.pop_front();
      av = e.d2 ? vec2 : vec1;
      ac = e.d2 ? {14'd0, cnt2} : cnt1;
      checks++;
      if (av !== e.v || ac !== e.c)
        $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 e.nm, av, ac, e.v, e.c);
      else
        passed++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    VZ   = '0;
    VF   = mk(0,0,1,0,0,2'b00,0,0,0,0);
    VDN  = mk(0,1,0,0,0,2'b00,0,0,0,0);
    VDB  = mk(1,1,0,0,0,2'b00,0,0,0,0);
    VH   = mk(0,0,0,0,0,2'b00,0,0,0,1);
    VADD = mk(0,0,0,0,1,2'b01,1,1,0,0);
    VSUB = mk(0,0,0,0,1,2'b10,1,1,0,0);
    VST  = mk(0,0,0,1,0,2'b00,0,0,1,0);
    VMV  = mk(0,0,0,0,1,2'b00,1,0,0,0);
    VLD  = mk(0,0,0,1,0,2'b00,1,0,0,0);

    cif.decoded_instruction = I_NOP;
    cif.zero_op = 0; cif.neg_op = 0;
    cif.unsigned_overflow = 0; cif.signed_overflow = 0;
    cif2.decoded_instruction = I_NOP;
    cif2.zero_op = 0; cif2.neg_op = 0;
    cif2.unsigned_overflow = 0; cif2.signed_overflow = 0;

    for (int i = 0; i < 3; i++)
      cyc("reset", 0, 0, 0, I_NOP, 0, 0, 0, VZ, 0);
    for (int i = 0; i < 10; i++)
      cyc("idle", 0, 1, 0, I_NOP, 0, 0, 0, VZ, 0);

    cyc("add_idle",  0, 1, 1, I_ADD, 0, 0, 0, VZ,   0);
    cyc("add_fetch", 0, 1, 0, I_ADD, 0, 0, 0, VF,   0);
    cyc("add_dec",   0, 1, 0, I_ADD, 0, 0, 0, VDN,  0);
    cyc("add_exec",  0, 1, 0, I_ADD, 0, 0, 0, VADD, 0);

    cyc("bz1_fetch", 0, 1, 0, I_BZERO, 1, 0, 0, VF,  1);
    cyc("bz1_dec",   0, 1, 0, I_BZERO, 1, 0, 0, VDB, 1);
    cyc("bz0_fetch", 0, 1, 0, I_BZERO, 0, 0, 0, VF,  2);
    cyc("bz0_dec",   0, 1, 0, I_BZERO, 0, 0, 0, VDN, 2);
    cyc("bnov_fetch",0, 1, 0, I_BNOV,  0, 0, 1, VF,  3);
    cyc("bnov_dec",  0, 1, 0, I_BNOV,  0, 0, 1, VDN, 3);
    cyc("bneg_fetch",0, 1, 0, I_BNEG,  0, 1, 0, VF,  4);
    cyc("bneg_dec",  0, 1, 0, I_BNEG,  0, 1, 0, VDB, 4);

    cyc("st_fetch",  0, 1, 0, I_STORE, 0, 0, 0, VF,  5);
    cyc("st_dec",    0, 1, 0, I_STORE, 0, 0, 0, VDN, 5);
    cyc("st_exec",   0, 1, 0, I_STORE, 0, 0, 0, VST, 5);
    cyc("mv_fetch",  0, 1, 0, I_MOVE,  0, 0, 0, VF,  6);
    cyc("mv_dec",    0, 1, 0, I_MOVE,  0, 0, 0, VDN, 6);
    cyc("mv_exec",   0, 1, 0, I_MOVE,  0, 0, 0, VMV, 6);
    cyc("sub_fetch", 0, 1, 0, I_SUB,   0, 0, 0, VF,  7);
    cyc("sub_dec",   0, 1, 0, I_SUB,   0, 0, 0, VDN, 7);
    cyc("sub_exec",  0, 1, 0, I_SUB,   0, 0, 0, VSUB,7);

    cyc("hlt_fetch", 0, 1, 0, I_HALT, 0, 0, 0, VF, 8);
    cyc("hlt_dec",   0, 1, 0, I_HALT, 0, 0, 0, VZ, 8);
    for (int i = 0; i < 20; i++)
      cyc("halted", 0, 1, 1, I_HALT, 0, 0, 0, VH, 9);
    cyc("hlt_rst",   0, 0, 0, I_NOP, 0, 0, 0, VZ, 0);
    cyc("post_rst",  0, 1, 0, I_NOP, 0, 0, 0, VZ, 0);

    cyc("ld_idle",   0, 1, 1, I_LOAD, 0, 0, 0, VZ,  0);
    cyc("ld_fetch",  0, 1, 0, I_LOAD, 0, 0, 0, VF,  0);
    cyc("ld_dec",    0, 1, 0, I_LOAD, 0, 0, 0, VDN, 0);
    cyc("ld_exec",   0, 1, 0, I_LOAD, 0, 0, 0, VLD, 0);
    cyc("ld2_fetch", 0, 1, 0, I_LOAD, 0, 0, 0, VF,  1);
    cyc("ld2_dec",   0, 1, 0, I_LOAD, 0, 0, 0, VDN, 1);
    cyc("ld2_rst",   0, 0, 0, I_LOAD, 0, 0, 0, VZ,  0);
    cyc("ld2_idle",  0, 1, 0, I_LOAD, 0, 0, 0, VZ,  0);

    cyc("sat_idle",  1, 1, 1, I_NOP, 0, 0, 0, VZ, 0);
    for (int i = 0; i <= 10; i++)
      cyc("sat_nop", 1, 1, 0, I_NOP, 0, 0, 0,
          (i % 2 == 0) ? VF : VDN, (i / 2 > 3) ? 3 : i / 2);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
